// File: rtl/sound_pkg.sv
// Shared sound codes and scheduler state encoding for the buzzer sound path.
package sound_pkg;

    localparam logic [2:0] SND_NONE     = 3'd0;
    localparam logic [2:0] SND_SELECT   = 3'd1;
    localparam logic [2:0] SND_DESELECT = 3'd2;
    localparam logic [2:0] SND_MOVE     = 3'd3;
    localparam logic [2:0] SND_CAPTURE  = 3'd4;
    localparam logic [2:0] SND_ILLEGAL  = 3'd5;
    localparam logic [2:0] SND_PROMOTE  = 3'd6;
    localparam logic [2:0] SND_GAMEOVER = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } snd_state_t;

endpackage

// File: rtl/sound_event_scheduler_if.sv
// Event-in / sound-out bundle between the game logic, the scheduler and the melody player.
interface sound_event_scheduler_if;

    logic [6:0] ev_req;
    logic [2:0] sound_code;
    logic       play_sound;
    logic       sound_start;
    logic       busy;
    logic [6:0] pending;

    modport master (
        input  ev_req,
        output sound_code, play_sound, sound_start, busy, pending
    );

    modport slave (
        output ev_req,
        input  sound_code, play_sound, sound_start, busy, pending
    );

endinterface

// File: rtl/snd_prio_pick.sv
// Combinational priority pick: highest set request bit wins; returns its code and a one-hot clear mask.
module snd_prio_pick
    import sound_pkg::*;
(
    input  logic [6:0] req,
    output logic [2:0] code,
    output logic [6:0] clr
);

    genvar gi;
    generate
        for (gi = 0; gi < 7; gi++) begin : g_onehot
            if (gi == 6) begin : g_top
                assign clr[gi] = req[gi];
            end else begin : g_lower
                assign clr[gi] = req[gi] & ~(|req[6:gi+1]);
            end
        end
    endgenerate

    always_comb begin
        code = SND_NONE;
        for (int i = 0; i < 7; i++) begin
            if (clr[i]) begin
                code = code | 3'(i + 1);
            end
        end
    end

endmodule

// File: rtl/sound_event_scheduler.sv
// Collects game-event strobes into a sticky mask and plays them one at a time,
// highest code first, each followed by a silent gap; game over preempts anything else.
module sound_event_scheduler
    import sound_pkg::*;
#(
    parameter int unsigned PLAY_CYCLES = 300_000_000,
    parameter int unsigned GAP_CYCLES  = 10_000_000,
    parameter int          CNT_W       = 29
) (
    input  logic                      clk,
    input  logic                      rst,
    sound_event_scheduler_if.master   bus
);

    localparam logic [CNT_W-1:0] PLAY_LOAD = CNT_W'(PLAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

    snd_state_t       state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [6:0]       pending_reg;
    logic [6:0]       pending_next;
    logic [2:0]       code_reg;
    logic             play_reg;
    logic             start_reg;
    logic             busy_reg;

    logic [2:0]       win_code;
    logic [6:0]       win_clr;
    logic             load_sound;
    logic             preempt;

    snd_prio_pick u_pick (
        .req  (pending_reg),
        .code (win_code),
        .clr  (win_clr)
    );

    // A new sound is launched from IDLE, or straight out of the last GAP cycle.
    always_comb begin
        load_sound   = (pending_reg != 7'd0) &&
                       ((state_reg == IDLE) || ((state_reg == GAP) && (cnt_reg == '0)));
        preempt      = pending_reg[6] && (code_reg != SND_GAMEOVER);
        pending_next = (pending_reg & ~(load_sound ? win_clr : 7'd0)) | bus.ev_req;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            pending_reg <= 7'd0;
            code_reg    <= SND_NONE;
            play_reg    <= 1'b0;
            start_reg   <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            pending_reg <= pending_next;
            start_reg   <= 1'b0;
            if (load_sound) begin
                state_reg <= PLAY;
                code_reg  <= win_code;
                cnt_reg   <= PLAY_LOAD;
                start_reg <= 1'b1;
                play_reg  <= 1'b1;
                busy_reg  <= 1'b1;
            end else begin
                case (state_reg)
                    PLAY: begin
                        // The interrupted sound is simply dropped; its bit was cleared at launch.
                        if (preempt || (cnt_reg == '0)) begin
                            state_reg <= GAP;
                            cnt_reg   <= GAP_LOAD;
                            code_reg  <= SND_NONE;
                            play_reg  <= 1'b0;
                        end else begin
                            cnt_reg <= cnt_reg - CNT_W'(1);
                        end
                    end
                    GAP: begin
                        if (cnt_reg == '0) begin
                            state_reg <= IDLE;
                            busy_reg  <= 1'b0;
                        end else begin
                            cnt_reg <= cnt_reg - CNT_W'(1);
                        end
                    end
                    IDLE: begin
                        busy_reg <= 1'b0;
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.sound_code  = code_reg;
    assign bus.play_sound  = play_reg;
    assign bus.sound_start = start_reg;
    assign bus.busy        = busy_reg;
    assign bus.pending     = pending_reg;

endmodule

// File: tb/tb_sound_event_scheduler.sv
// Directed bench for sound_event_scheduler with PLAY_CYCLES=8, GAP_CYCLES=3.
module tb_sound_event_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sound_event_scheduler_if bus ();

    sound_event_scheduler #(
        .PLAY_CYCLES (8),
        .GAP_CYCLES  (3),
        .CNT_W       (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    // Playback log built from the observed outputs.
    int   codes[$];
    int   lens[$];
    int   gaps[$];
    logic prev_play, prev_busy;
    int   cur_code, cur_len, gap_cnt, proto_err, rise_edge, busy_fall_edge;

    function automatic logic [31:0] pack4(input int q[$]);
        logic [31:0] r = 32'd0;
        foreach (q[i]) r = (r << 4) | 32'(q[i] & 15);
        return r;
    endfunction

    task automatic clear_log();
        codes.delete(); lens.delete(); gaps.delete();
        prev_play = bus.play_sound; prev_busy = bus.busy;
        cur_code = 0; cur_len = 0; gap_cnt = 0; proto_err = 0;
        rise_edge = -1; busy_fall_edge = -1;
    endtask

    task automatic observe();
        if (bus.play_sound) begin
            if (!bus.busy) proto_err++;
            if (!prev_play) begin
                cur_code = int'(bus.sound_code); cur_len = 1; rise_edge = cyc;
                if (!bus.sound_start || bus.sound_code == 3'd0) proto_err++;
                if (prev_busy) gaps.push_back(gap_cnt);
            end else begin
                cur_len++;
                if (bus.sound_start || int'(bus.sound_code) != cur_code) proto_err++;
            end
        end else begin
            if (bus.sound_code != 3'd0 || bus.sound_start) proto_err++;
            if (prev_play) begin
                codes.push_back(cur_code); lens.push_back(cur_len); gap_cnt = 0;
            end
            if (bus.busy) gap_cnt++;
            if (prev_busy && !bus.busy) busy_fall_edge = cyc;
        end
        prev_play = bus.play_sound;
        prev_busy = bus.busy;
    endtask

    // Present ev for one rising edge, then sample at the following falling edge.
    task automatic cycle(input logic [6:0] ev);
        bus.ev_req = ev;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        bus.ev_req = 7'd0;
        observe();
    endtask

    task automatic run_until_idle(input int bound);
        int n = 0;
        while ((bus.busy || bus.pending != 7'd0) && n < bound) begin
            cycle(7'd0);
            n++;
        end
        total++;
        if (bus.busy || bus.pending != 7'd0) $display("FAIL idle_timeout: busy=%0b pending=%b after %0d cycles, required idle", bus.busy, bus.pending, n);
        else passed++;
    endtask

    task automatic check_log(input string name, input logic [31:0] exp_codes, input logic [31:0] exp_lens,
                             input logic [31:0] exp_gaps);
        total++;
        if (pack4(codes) !== exp_codes) $display("FAIL %s_codes: got %h required %h", name, pack4(codes), exp_codes);
        else passed++;
        total++;
        if (pack4(lens) !== exp_lens) $display("FAIL %s_lens: got %h required %h", name, pack4(lens), exp_lens);
        else passed++;
        total++;
        if (pack4(gaps) !== exp_gaps) $display("FAIL %s_gaps: got %h required %h", name, pack4(gaps), exp_gaps);
        else passed++;
        total++;
        if (proto_err !== 0) $display("FAIL %s_protocol: got %0d violations required 0", name, proto_err);
        else passed++;
    endtask

    task automatic test_reset();
        bus.ev_req = 7'd0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        total++;
        if ({bus.sound_code, bus.play_sound, bus.sound_start, bus.busy} !== 6'd0)
            $display("FAIL reset_outputs: got %b required 000000", {bus.sound_code, bus.play_sound, bus.sound_start, bus.busy});
        else passed++;
        total++;
        if (bus.pending !== 7'd0) $display("FAIL reset_pending: got %b required 0000000", bus.pending);
        else passed++;
        clear_log();
        repeat (4) cycle(7'd0);
        total++;
        if (bus.busy !== 1'b0 || codes.size() != 0) $display("FAIL reset_quiet: busy=%b sounds=%0d required 0/0", bus.busy, codes.size());
        else passed++;
        $display("test_reset done");
    endtask

    task automatic test_single();
        int e;
        clear_log();
        cycle(7'b0000100);
        e = cyc;
        total++;
        if (bus.pending !== 7'b0000100 || bus.play_sound !== 1'b0)
            $display("FAIL single_latch: pending=%b play=%b required 0000100/0", bus.pending, bus.play_sound);
        else passed++;
        cycle(7'd0);
        total++;
        if (bus.play_sound !== 1'b1 || bus.sound_start !== 1'b1 || bus.sound_code !== 3'd3 || bus.busy !== 1'b1)
            $display("FAIL single_start: play=%b start=%b code=%0d busy=%b required 1/1/3/1",
                     bus.play_sound, bus.sound_start, bus.sound_code, bus.busy);
        else passed++;
        total++;
        if (bus.pending !== 7'd0) $display("FAIL single_clear: pending=%b required 0000000", bus.pending);
        else passed++;
        run_until_idle(40);
        total++;
        if (rise_edge !== e + 1 || busy_fall_edge !== e + 12)
            $display("FAIL single_timing: rise edge %0d busy-fall edge %0d required %0d/%0d", rise_edge, busy_fall_edge, e + 1, e + 12);
        else passed++;
        check_log("single", 32'h3, 32'h8, 32'h0);
        $display("test_single done");
    endtask

    task automatic test_simultaneous();
        clear_log();
        cycle(7'b0011001);
        run_until_idle(80);
        check_log("simul", 32'h541, 32'h888, 32'h33);
        $display("test_simultaneous done");
    endtask

    task automatic test_coalesce();
        clear_log();
        cycle(7'b0000100);
        repeat (2) cycle(7'd0);
        repeat (4) cycle(7'b0000010);
        cycle(7'b0000100);
        total++;
        if (bus.play_sound !== 1'b1 || bus.pending !== 7'b0000110)
            $display("FAIL coalesce_pending: play=%b pending=%b required 1/0000110", bus.play_sound, bus.pending);
        else passed++;
        run_until_idle(80);
        check_log("coalesce", 32'h332, 32'h888, 32'h33);
        $display("test_coalesce done");
    endtask

    task automatic test_preempt();
        clear_log();
        cycle(7'b0000001);
        repeat (4) cycle(7'd0);
        cycle(7'b1000000);
        run_until_idle(60);
        check_log("preempt", 32'h17, 32'h58, 32'h3);
        $display("test_preempt done");
    endtask

    task automatic test_gameover_repeat();
        clear_log();
        cycle(7'b1000000);
        repeat (3) cycle(7'd0);
        cycle(7'b1000000);
        run_until_idle(60);
        check_log("gameover", 32'h77, 32'h88, 32'h3);
        $display("test_gameover_repeat done");
    endtask

    task automatic test_reset_mid_play();
        clear_log();
        cycle(7'b0000001);
        cycle(7'd0);
        cycle(7'b0000110);
        total++;
        if (bus.play_sound !== 1'b1 || bus.pending !== 7'b0000110)
            $display("FAIL midreset_setup: play=%b pending=%b required 1/0000110", bus.play_sound, bus.pending);
        else passed++;
        rst = 1'b1;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if ({bus.sound_code, bus.play_sound, bus.sound_start, bus.busy, bus.pending} !== 13'd0)
            $display("FAIL midreset_outputs: code=%0d play=%b start=%b busy=%b pending=%b required all 0",
                     bus.sound_code, bus.play_sound, bus.sound_start, bus.busy, bus.pending);
        else passed++;
        clear_log();
        repeat (20) cycle(7'd0);
        total++;
        if (codes.size() != 0 || rise_edge != -1 || bus.busy !== 1'b0)
            $display("FAIL midreset_silent: sounds=%0d rise=%0d busy=%b required 0/-1/0", codes.size(), rise_edge, bus.busy);
        else passed++;
        cycle(7'b0000001);
        run_until_idle(40);
        check_log("midreset", 32'h1, 32'h8, 32'h0);
        $display("test_reset_mid_play done");
    endtask

    initial begin
        bus.ev_req = 7'd0;
        test_reset();
        test_single();
        test_simultaneous();
        test_coalesce();
        test_preempt();
        test_gameover_repeat();
        test_reset_mid_play();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sound_event_scheduler.md
# sound_event_scheduler

Upstream sequencer for the buzzer melody player. It collects one-cycle game-event strobes (select, deselect, move, capture, illegal, promote, game over) into a sticky pending mask. It serialises them by fixed priority and drives `sound_code`/`play_sound` for a fixed play window, followed by a silent gap. It also emits a start pulse so the player can restart its melody step counter for each new sound.

## Interface
Parameters:
- `PLAY_CYCLES`, 300_000_000: clock cycles `play_sound` is held per sound (48 melody steps × 6.25 M cycles at 100 MHz).
- `GAP_CYCLES`, 10_000_000: silent cycles between consecutive sounds; must be ≥1.
- `CNT_W`, 29: width of the window counter; must satisfy 2^CNT_W > max(PLAY_CYCLES, GAP_CYCLES).

Ports:
- `clk`, in, 1: system clock (100 MHz).
- `rst`, in, 1: reset; synchronous, active-high.
- `ev_req`, in, 7: event strobes, bit i-1 = sound code i (1 select … 7 game over). Each bit is a one-cycle pulse; any combination may be asserted together.
- `sound_code`, out, 3: code being played; 0 when not in PLAY.
- `play_sound`, out, 1: high for exactly the PLAY window.
- `sound_start`, out, 1: one-cycle pulse in the first PLAY cycle of each sound.
- `busy`, out, 1: high in PLAY or GAP.
- `pending`, out, 7: current sticky pending mask (debug/LED).

## Operation
- States: IDLE, PLAY, GAP. All outputs are registered.
- Pending mask update per edge: `pending_next = (pending & ~clr) | ev_req`. If a bit is set and cleared on the same edge, set wins.
- Priority: the highest set bit wins (7 > 6 > … > 1).
- IDLE:
  - If `pending != 0`: go to PLAY. Load `sound_code` with the winning code, clear that bit, counter := PLAY_CYCLES-1, assert `sound_start`.
  - Only the registered mask is examined; a same-cycle `ev_req` is seen next cycle.
- PLAY:
  - Counter decrements each cycle. At 0: go to GAP, counter := GAP_CYCLES-1.
  - Preemption: if `pending[6]` (code 7) is set and `sound_code != 7`, go to GAP immediately. The interrupted sound is discarded, not re-queued.
- GAP:
  - `sound_code`=0, `play_sound`=0. Counter decrements.
  - At 0: if `pending != 0`, go straight to PLAY as in IDLE (with `sound_start`); otherwise go to IDLE.
- Coalescing: repeated strobes of an already-pending code produce one playback. A strobe of the currently playing code re-arms it, so it plays again after the gap.
- Reset: state IDLE, `pending`=0, counter=0, `sound_code`=0, `play_sound`=0, `sound_start`=0, `busy`=0. Reset mid-PLAY drops the sound and all pending events on the next edge.

## Timing
- `ev_req` pulse sampled at edge k: `pending` bit visible after edge k. With the scheduler idle, `play_sound`/`sound_start` rise after edge k+1 (2-cycle latency).
- `play_sound` high for exactly PLAY_CYCLES cycles unless preempted. Preemption: `play_sound` falls on the edge after `pending[6]` becomes visible.
- Between sounds, `play_sound` is low for exactly GAP_CYCLES cycles.
- `sound_start` coincides with the first high cycle of `play_sound`. `sound_code` is stable for the whole window.
- `busy` is high from the first PLAY cycle through the last GAP cycle.

## Structure
- Shared package `sound_pkg`:
  - code constants `SND_NONE`=0, `SND_SELECT`=1, `SND_DESELECT`=2, `SND_MOVE`=3, `SND_CAPTURE`=4, `SND_ILLEGAL`=5, `SND_PROMOTE`=6, `SND_GAMEOVER`=7;
  - the state encoding (IDLE=0, PLAY=1, GAP=2).
- One sub-module: `snd_prio_pick`, a combinational 7-bit priority encoder producing the 3-bit winning code and a one-hot clear mask.
- The FSM, counter and pending mask stay in the top module.

## Test plan
Run with PLAY_CYCLES=8, GAP_CYCLES=3.
- Single event: `ev_req`=7'b0000100 at edge 5 → `play_sound` high cycles 7–14 with `sound_code`=3; `sound_start` only at cycle 7; `busy` low from cycle 18.
- Simultaneous events: `ev_req`=7'b0011001 at one edge → plays 5, then 4, then 1. Each lasts 8 cycles, separated by 3-cycle gaps, with no IDLE between.
- Coalescing: code 2 strobed 4 times while code 3 plays → code 2 plays exactly once afterward. Code 3 strobed during its own PLAY → code 3 plays again after the gap.
- Preemption: code 7 strobed at cycle 3 of a code-1 playback → `play_sound` falls after 5 cycles high. Gap is 3 cycles, then code 7 plays a full 8 cycles; code 1 never replays.
- Game over not preempted: code 7 strobed during code-7 playback → window completes (8 cycles), then code 7 plays again.
- Reset mid-PLAY with `pending`=7'b0000110 → after the reset edge all outputs are 0 and `pending`=0; no sound follows until a new strobe.
